oq_input_arbiter: RTL
=====================

OQ_INPUT_ARBITER -- requirements
Module: oq_input_arbiter

Interface
REQ-001 SHALL have parameter C_AXIS_DATA_WIDTH, default 256: tdata width of every stream.
REQ-002 SHALL have parameter C_AXIS_TUSER_WIDTH, default 128: tuser width of every stream.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 axi_aclk  in  1  sole clock; all logic rising-edge.
REQ-005 axi_reset  in  1  synchronous, active-high reset.
REQ-006 s_axis_tdata  in  4*C_AXIS_DATA_WIDTH  input i occupies slice i.
REQ-007 s_axis_tstrb  in  4*C_AXIS_DATA_WIDTH/8  per-input byte strobes.
REQ-008 s_axis_tuser  in  4*C_AXIS_TUSER_WIDTH  per-input sideband.
REQ-009 s_axis_tvalid  in  4  per-input valid.
REQ-010 s_axis_tlast  in  4  per-input end of packet.
REQ-011 s_axis_tready  out  4  per-input ready.
REQ-012 m_axis_tdata  out  C_AXIS_DATA_WIDTH  merged stream to the output queues.
REQ-013 m_axis_tstrb  out  C_AXIS_DATA_WIDTH/8  merged strobes.
REQ-014 m_axis_tuser  out  C_AXIS_TUSER_WIDTH  merged sideband, unmodified.
REQ-015 m_axis_tvalid  out  1  merged valid.
REQ-016 m_axis_tlast  out  1  merged end of packet.
REQ-017 m_axis_tready  in  1  downstream ready.
REQ-018 pkt_cnt  out  128  four 32-bit accepted-packet counters, input i in bits [32i+31:32i].

Function
REQ-019 SHALL implement FSM states IDLE and PKT, plus a 2-bit round-robin pointer rr_ptr and a 2-bit register grant.
REQ-020 In IDLE, if any s_axis_tvalid is set, grant SHALL load the first asserted input searching rr_ptr, rr_ptr+1, ... mod 4; next state SHALL be PKT.
REQ-021 In IDLE, m_axis_tvalid and all s_axis_tready SHALL be 0.
REQ-022 In PKT, m_axis_tdata/tstrb/tuser/tlast/tvalid SHALL equal input grant's fields, combinationally, with zero added latency.
REQ-023 In PKT, s_axis_tready[grant] SHALL equal m_axis_tready, and every other s_axis_tready bit SHALL be 0.
REQ-024 A beat transfers when m_axis_tvalid and m_axis_tready are both 1.
REQ-025 The grant SHALL hold for the whole packet; it SHALL NOT change while tvalid[grant] is deasserted mid-packet.
REQ-026 On a transfer with m_axis_tlast=1: next state SHALL be IDLE and rr_ptr SHALL be set to (grant+1) mod 4.
REQ-027 Each packet therefore SHALL cost exactly one IDLE arbitration cycle.
REQ-028 A single-beat packet (tlast on the first beat) SHALL be handled identically.
REQ-029 Simultaneous requests on all four inputs SHALL be served in rotating order: no input is granted twice while another requests.
REQ-030 In IDLE, tdata/tstrb/tuser/tlast outputs SHALL show input grant's fields; they are don't-care, but SHALL contain no X after reset.

Reset
REQ-031 While axi_reset=1 at a clock edge: state SHALL become IDLE, rr_ptr 0, grant 0, and pkt_cnt all zero.
REQ-032 Consequently, m_axis_tvalid=0 and s_axis_tready=4'b0000 in the first cycle after reset.
REQ-033 Reset mid-packet SHALL abandon the packet without completing it; the remainder is upstream's responsibility.

Configuration
REQ-034 Macro OQ_INPUT_ARBITER_PKT_CNT_EN: when defined, pkt_cnt[i] SHALL increment by 1 on each tlast transfer from input i.
REQ-035 The counter SHALL wrap from 0xFFFFFFFF to 0.
REQ-036 When the macro is undefined, pkt_cnt SHALL be constant 0 and no counter flops SHALL be inferred.

Verification
REQ-037 Input 2 only, 3-beat packet, m_axis_tready=1 -> 1 IDLE cycle, then 3 consecutive beats from input 2; rr_ptr=3 afterwards.
REQ-038 All 4 inputs each hold two 2-beat packets, tready=1 -> output order 0,1,2,3,0,1,2,3, with 1 gap cycle between packets.
REQ-039 Grant on input 1, tready toggles 1/0 each cycle, 4-beat packet -> beats forwarded only on tready=1; s_axis_tready[0,2,3] stay 0; beat data unchanged.
REQ-040 Input 0 mid-packet drops tvalid for 3 cycles while input 3 is valid -> grant stays 0, input 3 waits, input 3 is served after input 0's tlast.
REQ-041 axi_reset=1 asserted during beat 2 of a 4-beat packet -> next cycle m_axis_tvalid=0, state IDLE, rr_ptr=0; with the macro defined, pkt_cnt=0.
REQ-042 With the macro defined, 5 single-beat packets on input 3 -> pkt_cnt[127:96]=5, other counters 0; a counter preset near 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/oq_input_arbiter_if.sv
// Stream bundle for oq_input_arbiter: four packed AXIS inputs plus one merged output.
// The arbiter takes the slave modport; the upstream/downstream side takes master.
interface oq_input_arbiter_if #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128
);
  logic [4*C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata;
  logic [4*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb;
  logic [4*C_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser;
  logic [3:0]                       s_axis_tvalid;
  logic [3:0]                       s_axis_tlast;
  logic [3:0]                       s_axis_tready;
  logic [C_AXIS_DATA_WIDTH-1:0]     m_axis_tdata;
  logic [C_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb;
  logic [C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser;
  logic                             m_axis_tvalid;
  logic                             m_axis_tlast;
  logic                             m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    input  m_axis_tready,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    output m_axis_tready,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/oq_input_arbiter.sv
// Four-input packet-level round-robin merger feeding the output queues.
// Optional per-input packet counters are enabled by defining OQ_INPUT_ARBITER_PKT_CNT_EN.
module oq_input_arbiter #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                  axi_aclk,
  input  logic                  axi_reset,
  oq_input_arbiter_if.slave     axis,
  output logic [127:0]          pkt_cnt
);
  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_AXIS_TUSER_WIDTH;

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;
  logic       last_xfer;

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= 2'd0;
      grant_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  // First requester at or after rr_ptr, wrapping mod 4.
  always_comb begin
    pick  = rr_ptr_q;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr_q + 2'(i);
      if (!found && axis.s_axis_tvalid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Datapath always mirrors the granted input so IDLE outputs are never X.
  always_comb begin
    axis.m_axis_tdata  = axis.s_axis_tdata[int'(grant_q)*DW +: DW];
    axis.m_axis_tstrb  = axis.s_axis_tstrb[int'(grant_q)*SW +: SW];
    axis.m_axis_tuser  = axis.s_axis_tuser[int'(grant_q)*UW +: UW];
    axis.m_axis_tlast  = axis.s_axis_tlast[grant_q];
    axis.m_axis_tvalid = (state_q == PKT) && axis.s_axis_tvalid[grant_q];
    axis.s_axis_tready = 4'b0000;
    if (state_q == PKT) begin
      axis.s_axis_tready[grant_q] = axis.m_axis_tready;
    end
  end

  assign last_xfer = axis.m_axis_tvalid && axis.m_axis_tready && axis.m_axis_tlast;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = PKT;
        end
      end
      PKT: begin
        if (last_xfer) begin
          state_d  = IDLE;
          rr_ptr_d = grant_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef OQ_INPUT_ARBITER_PKT_CNT_EN
  logic [3:0][31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (last_xfer) begin
      cnt_d[grant_q] = cnt_q[grant_q] + 32'd1;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pkt_cnt = cnt_q;
`else
  assign pkt_cnt = '0;
`endif
endmodule
